dest_router: RTL and testbench
==============================

# dest_router

Pop-and-route stage directly upstream of the D0/D1 destination FIFOs. It drains one source (virtual-channel) FIFO and steers each word to D0 or D1 by a destination bit. It throttles on either destination's almost-full flag and flags any write into a full FIFO. Its D1 outputs connect straight to the D1 FIFO wrapper's write/data inputs.

## Interface
- BW, 6, data word width; must equal the destination FIFOs' BW
- DEST_BIT, 4, index of the routing bit in the word: 0 routes to D0, 1 routes to D1
- CNT_W, 8, width of the per-destination word counters
- clk  in  1  sole clock, rising edge
- reset_L  in  1  asynchronous, active-low reset
- src_empty  in  1  source FIFO empty flag
- src_data  in  BW  source FIFO data_out; valid the cycle after src_rd
- src_rd  out  1  source FIFO pop
- D0_almost_full, D1_almost_full  in  1  destination threshold flags
- D0_full, D1_full  in  1  destination full flags
- D0_wr, D1_wr  out  1  destination write strobes; at most one high per cycle
- D_data_out  out  BW  registered word, shared by D0 and D1 data inputs
- router_error  out  1  sticky, set on a write attempt into a full FIFO
- cnt_D0, cnt_D1  out  CNT_W  words delivered per destination (see Configuration)
- router_state  out  2  FSM state, for debug

## Operation
- Reset (reset_L low, asynchronous): all outputs 0, router_state=IDLE, in-flight flags cleared.
- stall = D0_almost_full | D1_almost_full. The destination is unknown before the read, so either flag stalls.
- src_rd = !src_empty & !stall & state!=PAUSE. This is combinational from the registered state and the inputs.
- Pipeline:
  - pend_q is set the cycle after src_rd=1, when src_data is valid.
  - On that cycle's edge, D_data_out<=src_data.
  - The write strobe D{src_data[DEST_BIT]}_wr<=1 for one cycle.
  - Otherwise both strobes register 0.
- FSM encoding: IDLE=0, ACTIVE=1, PAUSE=2.
  - IDLE: moves to ACTIVE when src_rd=1.
  - ACTIVE:
    - Moves to PAUSE when stall=1.
    - Else moves to IDLE when src_empty=1 and pend_q=0.
    - Else stays in ACTIVE.
  - PAUSE: returns to ACTIVE when stall=0 and src_empty=0; returns to IDLE when stall=0 and src_empty=1.
  - Entering PAUSE never discards pend_q. The in-flight word still issues.
- Full-write error: if the selected D*_full=1 on the cycle the strobe would be registered:
  - The strobe is suppressed and the word is dropped.
  - router_error<=1 and holds until reset.
  - The counter does not increment.
- Integration rule: each destination almost-full threshold leaves at least 2 free entries. This covers the worst case of one pending word plus one issued write.

## Timing
- Latency: src_rd high at cycle N → src_data captured at edge N+1 → D*_wr high and D_data_out valid during cycle N+2.
- Throughput: 1 word/cycle with no stall.
- Stall response: almost_full seen in cycle N gives src_rd=0 in cycle N. At most one word already popped still issues at N+1.
- Empty: src_rd never asserts while src_empty=1. No bubble is inserted on refill.
- Simultaneous stall deassert and src_empty=0 in PAUSE: src_rd asserts the same cycle as the move to ACTIVE.
- Counter wrap: cnt_D* rolls from 2^CNT_W−1 to 0 with no flag.
- Reset mid-operation: the in-flight word is lost and no strobe is emitted after reset. Resynchronising the source FIFO is the caller's responsibility.

## Configuration
- DEST_ROUTER_CNT_EN
  - Defined: cnt_D0/cnt_D1 increment on each issued D0_wr/D1_wr.
  - Undefined: counter registers are not built and the cnt outputs are tied to 0.
  - FSM, routing, and error behaviour are identical in both builds.

## Test plan
- Route mix: push 0x12, 0x05, 0x1F, 0x00 into the source FIFO with no stall → D1_wr carries 0x12, 0x1F; D0_wr carries 0x05, 0x00; each write 2 cycles after its src_rd; cnt_D1=2, cnt_D0=2.
- Backpressure: raise D1_almost_full mid-burst of 6 words → src_rd drops the same cycle; ≤1 further strobe; state=PAUSE(2); release → remaining words delivered in order with no loss or duplicates.
- Full error: force D0_full=1 while 0x03 is in flight → no D0_wr; router_error=1 and stays set; cnt_D0 unchanged.
- Empty idle: source empty for 10 cycles → src_rd=0, both strobes 0, state=IDLE(0).
- Reset mid-burst: assert reset_L=0 between src_rd and the strobe → all outputs 0 asynchronously; no strobe after release; counters 0.
- Wrap: with DEST_ROUTER_CNT_EN, send 256 D0 words → cnt_D0=0; without the macro, cnt outputs stay 0 throughout.

Source files
------------

// File: rtl/dest_router.sv
// Pops one source FIFO and steers each word to destination D0 or D1 by a routing bit.
// Optional per-destination delivery counters are built when DEST_ROUTER_CNT_EN is defined.
module dest_router #(
   parameter int BW       = 6,
   parameter int DEST_BIT = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             src_empty,
   input  logic [BW-1:0]    src_data,
   output logic             src_rd,
   input  logic             D0_almost_full,
   input  logic             D1_almost_full,
   input  logic             D0_full,
   input  logic             D1_full,
   output logic             D0_wr,
   output logic             D1_wr,
   output logic [BW-1:0]    D_data_out,
   output logic             router_error,
   output logic [CNT_W-1:0] cnt_D0,
   output logic [CNT_W-1:0] cnt_D1,
   output logic [1:0]       router_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      PAUSE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            pend_q, pend_d;
   logic            d0_wr_q, d0_wr_d;
   logic            d1_wr_q, d1_wr_d;
   logic [BW-1:0]   data_q, data_d;
   logic            err_q, err_d;
   logic            stall;
   logic            dest_d1;
   logic            full_sel;

   always_comb begin
      // The destination is unknown until the word is read, so either flag throttles.
      stall    = D0_almost_full | D1_almost_full;
      src_rd   = !src_empty && !stall && (state_q != PAUSE);
      pend_d   = src_rd;
      dest_d1  = src_data[DEST_BIT];
      full_sel = dest_d1 ? D1_full : D0_full;
      data_d   = pend_q ? src_data : data_q;
      d0_wr_d  = pend_q && !dest_d1 && !D0_full;
      d1_wr_d  = pend_q &&  dest_d1 && !D1_full;
      err_d    = err_q | (pend_q & full_sel);

      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (src_rd) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (stall)                      state_d = PAUSE;
            else if (src_empty && !pend_q)  state_d = IDLE;
         end
         PAUSE: begin
            if (!stall) state_d = src_empty ? IDLE : ACTIVE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         d0_wr_q <= 1'b0;
         d1_wr_q <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         d0_wr_q <= d0_wr_d;
         d1_wr_q <= d1_wr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign D0_wr        = d0_wr_q;
   assign D1_wr        = d1_wr_q;
   assign D_data_out   = data_q;
   assign router_error = err_q;
   assign router_state = state_q;

`ifdef DEST_ROUTER_CNT_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   // Counters advance on the same edge that registers the strobe; wrap silently.
   always_comb begin
      cnt0_d = cnt0_q + CNT_W'(d0_wr_d);
      cnt1_d = cnt1_q + CNT_W'(d1_wr_d);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt_D0 = cnt0_q;
   assign cnt_D1 = cnt1_q;
`else
   assign cnt_D0 = '0;
   assign cnt_D1 = '0;
`endif

endmodule

// File: tb/tb_dest_router.sv
// Bench for dest_router: behavioural source FIFO plus an expected-delivery queue
// that predicts every strobe, its data, its cycle, drops, the error flag and counters.
module tb_dest_router;

   localparam int BW    = 6;
   localparam int DB    = 4;
   localparam int CNT_W = 8;
`ifdef DEST_ROUTER_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_L;
   logic             src_empty;
   logic [BW-1:0]    src_data;
   logic             src_rd;
   logic             D0_almost_full, D1_almost_full;
   logic             D0_full, D1_full;
   logic             D0_wr, D1_wr;
   logic [BW-1:0]    D_data_out;
   logic             router_error;
   logic [CNT_W-1:0] cnt_D0, cnt_D1;
   logic [1:0]       router_state;

   dest_router #(.BW(BW), .DEST_BIT(DB), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_L(reset_L),
      .src_empty(src_empty), .src_data(src_data), .src_rd(src_rd),
      .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
      .D0_full(D0_full), .D1_full(D1_full),
      .D0_wr(D0_wr), .D1_wr(D1_wr), .D_data_out(D_data_out),
      .router_error(router_error), .cnt_D0(cnt_D0), .cnt_D1(cnt_D1),
      .router_state(router_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BW-1:0] w;
      int            due;
      bit            drop;
   } ent_t;

   ent_t          exp_q[$];
   logic [BW-1:0] src_q[$];
   logic [BW-1:0] pend_w;
   bit            pend_v;
   bit            kaf0, kaf1, kf0, kf1;
   bit            err_exp;
   int            cnt0, cnt1;
   int            cyc;
   int            first_rd, last_rd;
   int            n_assert, n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // One clock cycle: check registered outputs, advance the source FIFO, drive inputs.
   task automatic cycle();
      ent_t e;
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         if (e.drop) begin
            err_exp = 1'b1;
            chk("drop_no_wr", {30'd0, D1_wr, D0_wr}, 32'd0);
         end else begin
            chk("wr_dest", {30'd0, D1_wr, D0_wr}, e.w[DB] ? 32'd2 : 32'd1);
            chk("data", {26'd0, D_data_out}, {26'd0, e.w});
            if (e.w[DB]) cnt1 = (cnt1 + 1) % 256;
            else         cnt0 = (cnt0 + 1) % 256;
         end
      end else begin
         chk("no_wr", {30'd0, D1_wr, D0_wr}, 32'd0);
      end
      chk("err", {31'd0, router_error}, {31'd0, err_exp});
      chk("cnt0", {24'd0, cnt_D0}, CNT_EN ? cnt0 : 0);
      chk("cnt1", {24'd0, cnt_D1}, CNT_EN ? cnt1 : 0);

      D0_full = kf0;
      D1_full = kf1;
      D0_almost_full = kaf0;
      D1_almost_full = kaf1;
      if (pend_v) begin
         src_data = pend_w;
         e.w    = pend_w;
         e.due  = cyc + 1;
         e.drop = pend_w[DB] ? kf1 : kf0;
         exp_q.push_back(e);
         pend_v = 1'b0;
      end
      src_empty = (src_q.size() == 0);
      #1;
      if (src_empty || kaf0 || kaf1) chk("rd_blocked", {31'd0, src_rd}, 32'd0);
      if (src_rd === 1'b1 && src_q.size() > 0) begin
         pend_w = src_q.pop_front();
         pend_v = 1'b1;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      n_assert = 0; n_fail = 0; cyc = 0; cnt0 = 0; cnt1 = 0; err_exp = 0;
      pend_v = 0; kaf0 = 0; kaf1 = 0; kf0 = 0; kf1 = 0;
      first_rd = -1; last_rd = -1;
      reset_L = 1'b0; src_empty = 1'b1; src_data = '0;
      D0_almost_full = 0; D1_almost_full = 0; D0_full = 0; D1_full = 0;

      // Reset state
      #2;
      chk("rst_wr", {30'd0, D1_wr, D0_wr}, 32'd0);
      chk("rst_data", {26'd0, D_data_out}, 32'd0);
      chk("rst_err", {31'd0, router_error}, 32'd0);
      chk("rst_state", {30'd0, router_state}, 32'd0);
      chk("rst_cnt", {16'd0, cnt_D1, cnt_D0}, 32'd0);
      @(negedge clk);
      reset_L = 1'b1;

      // Empty idle
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("idle_rd", {31'd0, src_rd}, 32'd0);
         chk("idle_state", {30'd0, router_state}, 32'd0);
      end

      // Route mix, back to back
      src_q.push_back(6'h12); src_q.push_back(6'h05);
      src_q.push_back(6'h1F); src_q.push_back(6'h00);
      first_rd = -1;
      run(8);
      chk("mix_rd_span", last_rd - first_rd, 32'd3);
      chk("mix_cnt1", {24'd0, cnt_D1}, CNT_EN ? 32'd2 : 32'd0);
      chk("mix_cnt0", {24'd0, cnt_D0}, CNT_EN ? 32'd2 : 32'd0);
      chk("mix_drained", exp_q.size(), 32'd0);

      // Backpressure mid-burst
      for (int i = 0; i < 6; i++) src_q.push_back(6'($urandom_range(0, 63)));
      run(2);
      kaf1 = 1'b1;
      run(4);
      chk("bp_state", {30'd0, router_state}, 32'd2);
      chk("bp_left", src_q.size(), 32'd4);
      kaf1 = 1'b0;
      run(12);
      chk("bp_drained", exp_q.size() + src_q.size(), 32'd0);

      // Randomized traffic with sporadic almost-full on either side
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) src_q.push_back(6'($urandom_range(0, 63)));
         if ($urandom_range(0, 9) == 0) kaf0 = ~kaf0;
         if ($urandom_range(0, 9) == 0) kaf1 = ~kaf1;
         cycle();
      end
      kaf0 = 0; kaf1 = 0;
      run(src_q.size() + 8);
      chk("rand_drained", exp_q.size() + src_q.size(), 32'd0);

      // Write into a full D0 FIFO
      src_q.push_back(6'h03);
      for (int i = 0; i < 8; i++) begin
         kf0 = pend_v;
         cycle();
      end
      kf0 = 0;
      chk("full_err", {31'd0, router_error}, 32'd1);
      run(3);
      chk("full_err_sticky", {31'd0, router_error}, 32'd1);

      // Reset while a word is in flight
      for (int i = 0; i < 3; i++) src_q.push_back(6'($urandom_range(0, 63)));
      run(2);
      reset_L = 1'b0;
      #1;
      chk("mid_rst_wr", {30'd0, D1_wr, D0_wr}, 32'd0);
      chk("mid_rst_data", {26'd0, D_data_out}, 32'd0);
      chk("mid_rst_err", {31'd0, router_error}, 32'd0);
      chk("mid_rst_state", {30'd0, router_state}, 32'd0);
      chk("mid_rst_cnt", {16'd0, cnt_D1, cnt_D0}, 32'd0);
      exp_q.delete(); src_q.delete();
      pend_v = 0; err_exp = 0; cnt0 = 0; cnt1 = 0;
      src_empty = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_L = 1'b1;
      run(6);

      // Counter wrap: 256 words to D0
      for (int i = 0; i < 256; i++)
         src_q.push_back({1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15))});
      run(266);
      chk("wrap_cnt0", {24'd0, cnt_D0}, 32'd0);
      chk("wrap_cnt1", {24'd0, cnt_D1}, 32'd0);
      chk("wrap_drained", exp_q.size() + src_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
